// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
package sys_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Combinational two-way picker: lock owner first, then fixed priority or round-robin.
module arb_rr2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       lockValid_i,
    input  logic       lockOwner_i,
    output logic       winner_o
);

    always_comb begin
        winner_o = 1'b0;
        case (req_i)
            2'b10: winner_o = 1'b1;
            2'b11: begin
                if (lockValid_i) begin
                    winner_o = lockOwner_i;
                end else if (FIXED_PRIO) begin
                    winner_o = 1'b0;
                end else begin
                    winner_o = ~last_i;
                end
            end
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-master, one-slave bus arbiter with registered slave request and
// timeout-to-error completion so a dead slave cannot stall the CPU.
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int          TIMEOUT    = 16,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_be,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,
    output logic        busy
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

    state_t        state_q;
    logic          last_q;
    logic          lockValid_q;
    logic          lockOwner_q;
    logic          owner_q;
    logic [CW-1:0] cnt_q;
    bus_req_t      busReq_q;
    logic          sReq_q;
    logic [1:0]    ack_q;
    logic [1:0]    err_q;
    logic [31:0]   m0Rdata_q;
    logic [31:0]   m1Rdata_q;

    logic [1:0] reqVec;
    logic       win;
    bus_req_t   m0Bus;
    bus_req_t   m1Bus;

    assign reqVec = {m1_req, m0_req};
    assign m0Bus  = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, be: m0_be};
    assign m1Bus  = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, be: m1_be};

    arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) uArb (
        .req_i       (reqVec),
        .last_i      (last_q),
        .lockValid_i (lockValid_q),
        .lockOwner_i (lockOwner_q),
        .winner_o    (win)
    );

    // The grant is the only output decided in the same cycle as the request.
    assign m0_gnt = (state_q == IDLE) && (|reqVec) && (win == M_CPU);
    assign m1_gnt = (state_q == IDLE) && (|reqVec) && (win == M_DMA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= M_DMA;
            lockValid_q <= 1'b0;
            lockOwner_q <= M_CPU;
            owner_q     <= M_CPU;
            cnt_q       <= '0;
            busReq_q    <= '0;
            sReq_q      <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            m0Rdata_q   <= '0;
            m1Rdata_q   <= '0;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    // A lock only survives one arbitration opportunity.
                    lockValid_q <= 1'b0;
                    if (|reqVec) begin
                        owner_q  <= win;
                        busReq_q <= win ? m1Bus : m0Bus;
                        cnt_q    <= '0;
                        sReq_q   <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ack || (cnt_q == CntLast)) begin
                        sReq_q          <= 1'b0;
                        ack_q[owner_q]  <= 1'b1;
                        err_q[owner_q]  <= ~s_ack;
                        if (!busReq_q.we) begin
                            if (owner_q == M_DMA) begin
                                m1Rdata_q <= s_ack ? s_rdata : ERR_DATA;
                            end else begin
                                m0Rdata_q <= s_ack ? s_rdata : ERR_DATA;
                            end
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    last_q      <= owner_q;
                    lockOwner_q <= owner_q;
                    lockValid_q <= (owner_q == M_DMA) ? m1_lock : m0_lock;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_req    = sReq_q;
    assign s_we     = busReq_q.we;
    assign s_addr   = busReq_q.addr;
    assign s_wdata  = busReq_q.wdata;
    assign s_be     = busReq_q.be;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rdata = m0Rdata_q;
    assign m1_rdata = m1Rdata_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter: one round-robin and one fixed-priority
// instance share the master stimulus; outputs of the selected instance are checked.
module tb_sys_bus_arbiter;

    localparam logic [31:0] K    = 32'hCAFE_E009;
    localparam logic [31:0] ERRD = 32'hBAD0_BAD0;
    localparam int          TMO  = 16;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        lock;
    } txn_t;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_be = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_be = '0;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = '0;

    logic        m0GntV [2], m0AckV [2], m0ErrV [2];
    logic        m1GntV [2], m1AckV [2], m1ErrV [2];
    logic [31:0] m0RdataV [2], m1RdataV [2];
    logic        sReqV [2], sWeV [2], busyV [2];
    logic [31:0] sAddrV [2], sWdataV [2];
    logic [3:0]  sBeV [2];

    bit dutSel = 1'b0;

    for (genvar g = 0; g < 2; g++) begin : gDut
        sys_bus_arbiter #(.TIMEOUT(TMO), .FIXED_PRIO(g == 1), .ERR_DATA(ERRD)) uDut (
            .clk(clk), .rst(rst),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_be(m0_be), .m0_lock(m0_lock), .m0_gnt(m0GntV[g]), .m0_ack(m0AckV[g]),
            .m0_err(m0ErrV[g]), .m0_rdata(m0RdataV[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1GntV[g]), .m1_ack(m1AckV[g]),
            .m1_err(m1ErrV[g]), .m1_rdata(m1RdataV[g]),
            .s_req(sReqV[g]), .s_we(sWeV[g]), .s_addr(sAddrV[g]), .s_wdata(sWdataV[g]),
            .s_be(sBeV[g]), .s_ack(s_ack), .s_rdata(s_rdata), .busy(busyV[g])
        );
    end

    logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        s_req, s_we, busy;
    logic [3:0]  s_be;

    assign m0_gnt = m0GntV[dutSel];     assign m1_gnt = m1GntV[dutSel];
    assign m0_ack = m0AckV[dutSel];     assign m1_ack = m1AckV[dutSel];
    assign m0_err = m0ErrV[dutSel];     assign m1_err = m1ErrV[dutSel];
    assign m0_rdata = m0RdataV[dutSel]; assign m1_rdata = m1RdataV[dutSel];
    assign s_req = sReqV[dutSel];       assign s_we = sWeV[dutSel];
    assign s_addr = sAddrV[dutSel];     assign s_wdata = sWdataV[dutSel];
    assign s_be = sBeV[dutSel];         assign busy = busyV[dutSel];

    txn_t        tx0Q[$], tx1Q[$], slvQ[$];
    exp_t        expQ[$];
    logic [31:0] predRd [2];
    logic [31:0] shadowRd [2];
    int          nChecks = 0, nPass = 0;
    int          slvWait = 0, busyCnt = 0, curLen = 0, lastReqLen = 0;
    bit          slvMute = 1'b0, sReqPrev = 1'b0;
    logic [31:0] heldAddr = '0;
    txn_t        monT;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input logic lock);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.be = be; t.lock = lock;
        return t;
    endfunction

    // Reads return addr + K, so the expected read data is known when queued.
    task automatic expectTxn(input int m, input txn_t t, input logic err);
        exp_t e;
        slvQ.push_back(t);
        if (!t.we) predRd[m] = err ? ERRD : t.addr + K;
        e.m = m; e.err = err; e.rdata = predRd[m];
        expQ.push_back(e);
    endtask

    task automatic driveMaster(input int m, input logic req, input txn_t t);
        if (m == 0) begin
            m0_req = req; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata; m0_be = t.be; m0_lock = t.lock;
        end else begin
            m1_req = req; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata; m1_be = t.be; m1_lock = t.lock;
        end
    endtask

    task automatic applyStimulus(input int m);
        txn_t t;
        int   guard;
        bit   done;
        forever begin
            if (m == 0) begin
                if (tx0Q.size() == 0) break;
                t = tx0Q.pop_front();
            end else begin
                if (tx1Q.size() == 0) break;
                t = tx1Q.pop_front();
            end
            driveMaster(m, 1'b1, t);
            guard = 0;
            done  = 1'b0;
            while (!done && guard < 100) begin
                @(negedge clk);
                done = (m == 0) ? m0_ack : m1_ack;
                guard++;
            end
            if (!done) checkOutput(m == 0 ? "ack_wait_m0" : "ack_wait_m1", 0, 1);
            @(posedge clk); #1;
        end
        driveMaster(m, 1'b0, mk(0, 0, 0, 0, 0));
    endtask

    task automatic applyReset(input bit sel);
        @(posedge clk); #1;
        rst = 1'b1;
        dutSel = sel;
        driveMaster(0, 1'b0, mk(0, 0, 0, 0, 0));
        driveMaster(1, 1'b0, mk(0, 0, 0, 0, 0));
        slvMute = 1'b0;
        slvWait = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        predRd[0] = '0; predRd[1] = '0; shadowRd[0] = '0; shadowRd[1] = '0;
    endtask

    task automatic checkAck(input int m);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_ack", 1, 0);
            return;
        end
        e = expQ.pop_front();
        checkOutput("ack_owner", m, e.m);
        checkOutput("ack_err", m ? m1_err : m0_err, e.err);
        checkOutput("ack_rdata", m ? m1_rdata : m0_rdata, e.rdata);
        shadowRd[m] = e.rdata;
        checkOutput("loser_rdata", m ? m0_rdata : m1_rdata, shadowRd[1 - m]);
    endtask

    // Slave model: acks after slvWait extra cycles unless muted.
    always @(negedge clk) begin
        if (s_req) begin
            busyCnt++;
            s_ack   = !slvMute && (busyCnt == slvWait + 1);
            s_rdata = s_addr + K;
        end else begin
            busyCnt = 0;
            s_ack   = 1'b0;
            s_rdata = 32'hDEAD_BEEF;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            sReqPrev = 1'b0;
            curLen   = 0;
        end else begin
            if (m0_ack && m1_ack) checkOutput("dual_ack", 2'b11, 2'b01);
            else if (m0_ack || m1_ack) checkAck(m1_ack ? 1 : 0);
            if (s_req && !sReqPrev) begin
                if (slvQ.size() == 0) begin
                    checkOutput("unexpected_sreq", 1, 0);
                end else begin
                    monT = slvQ.pop_front();
                    checkOutput("s_we", s_we, monT.we);
                    checkOutput("s_addr", s_addr, monT.addr);
                    checkOutput("s_wdata", s_wdata, monT.wdata);
                    checkOutput("s_be", s_be, monT.be);
                end
                heldAddr = s_addr;
            end else if (s_req && s_addr !== heldAddr) begin
                checkOutput("s_addr_stable", s_addr, heldAddr);
            end
            if (s_req) begin
                curLen++;
            end else begin
                if (sReqPrev) lastReqLen = curLen;
                curLen = 0;
            end
            sReqPrev = s_req;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        txn_t t;
        int   guard;
        predRd[0] = '0; predRd[1] = '0; shadowRd[0] = '0; shadowRd[1] = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_sreq", s_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_m1_rdata", m1_rdata, 0);
        checkOutput("rst_saddr", s_addr, 0);
        checkOutput("rst_sbe", s_be, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_m0_gnt", m0_gnt, 0);
        checkOutput("idle_m0_ack", m0_ack, 0);
        checkOutput("idle_m0_err", m0_err, 0);

        // Single zero-wait CPU read with cycle-exact latency.
        @(posedge clk); #1;
        t = mk(0, 32'h0000_1004, 0, 4'hF, 0);
        expectTxn(0, t, 0);
        driveMaster(0, 1'b1, t);
        @(negedge clk);
        checkOutput("A_gnt_t", m0_gnt, 1);
        checkOutput("A_m1_gnt_t", m1_gnt, 0);
        checkOutput("A_sreq_t", s_req, 0);
        @(negedge clk);
        checkOutput("A_sreq_t1", s_req, 1);
        checkOutput("A_busy_t1", busy, 1);
        checkOutput("A_ack_t1", m0_ack, 0);
        @(negedge clk);
        checkOutput("A_ack_t2", m0_ack, 1);
        checkOutput("A_sreq_t2", s_req, 0);
        @(posedge clk); #1 driveMaster(0, 1'b0, t);
        repeat (3) @(negedge clk);
        checkOutput("A_drained", expQ.size(), 0);

        // Round-robin from reset with both masters held.
        applyReset(0);
        tx0Q.push_back(mk(0, 32'h100, 0, 4'hF, 0));
        tx0Q.push_back(mk(0, 32'h104, 0, 4'hF, 0));
        tx1Q.push_back(mk(0, 32'h200, 0, 4'hF, 0));
        tx1Q.push_back(mk(1, 32'h204, 32'h1234_5678, 4'hF, 0));
        expectTxn(0, tx0Q[0], 0);
        expectTxn(1, tx1Q[0], 0);
        expectTxn(0, tx0Q[1], 0);
        expectTxn(1, tx1Q[1], 0);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join
        checkOutput("B_drained", expQ.size(), 0);

        // Lock keeps the grant with m1 for one extra round.
        applyReset(0);
        tx0Q.push_back(mk(0, 32'h600, 0, 4'hF, 0));
        tx0Q.push_back(mk(0, 32'h604, 0, 4'hF, 0));
        tx1Q.push_back(mk(0, 32'h700, 0, 4'hF, 1));
        tx1Q.push_back(mk(0, 32'h704, 0, 4'hF, 1));
        expectTxn(0, tx0Q[0], 0);
        expectTxn(1, tx1Q[0], 0);
        expectTxn(1, tx1Q[1], 0);
        expectTxn(0, tx0Q[1], 0);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join
        checkOutput("E_drained", expQ.size(), 0);

        // Timeout, then an ack landing exactly on the last allowed cycle.
        applyReset(0);
        slvMute = 1'b1;
        tx1Q.push_back(mk(0, 32'h500, 0, 4'hF, 0));
        expectTxn(1, tx1Q[0], 1);
        applyStimulus(1);
        checkOutput("D_len_timeout", lastReqLen, TMO);
        slvMute = 1'b0;
        slvWait = TMO - 1;
        tx1Q.push_back(mk(0, 32'h504, 0, 4'hF, 0));
        expectTxn(1, tx1Q[0], 0);
        applyStimulus(1);
        checkOutput("D_len_lastack", lastReqLen, TMO);
        checkOutput("D_drained", expQ.size(), 0);

        // Fixed priority: m0 byte writes all go ahead of the waiting m1.
        applyReset(1);
        tx0Q.push_back(mk(1, 32'h401, 32'h0000_1100, 4'b0010, 0));
        tx0Q.push_back(mk(1, 32'h405, 32'h0000_2200, 4'b0010, 0));
        tx0Q.push_back(mk(1, 32'h409, 32'h0000_3300, 4'b0010, 0));
        tx1Q.push_back(mk(0, 32'h300, 0, 4'hF, 0));
        expectTxn(0, tx0Q[0], 0);
        expectTxn(0, tx0Q[1], 0);
        expectTxn(0, tx0Q[2], 0);
        expectTxn(1, tx1Q[0], 0);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join
        checkOutput("C_drained", expQ.size(), 0);

        // Asynchronous reset in the middle of a stalled transaction.
        applyReset(0);
        slvMute = 1'b1;
        t = mk(0, 32'h800, 0, 4'hF, 0);
        slvQ.push_back(t);
        expectTxn(0, t, 0);
        driveMaster(0, 1'b1, t);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!s_req && guard < 20);
        checkOutput("F_sreq_seen", s_req, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checkOutput("F_sreq_async", s_req, 0);
        checkOutput("F_busy_async", busy, 0);
        checkOutput("F_noack", m0_ack, 0);
        slvMute = 1'b0;
        shadowRd[0] = '0;
        shadowRd[1] = '0;
        @(negedge clk);
        checkOutput("F_noack_rst", m0_ack, 0);
        @(posedge clk); #1 rst = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!m0_ack && guard < 20);
        checkOutput("F_retry_ack", m0_ack, 1);
        @(posedge clk); #1 driveMaster(0, 1'b0, t);
        repeat (3) @(negedge clk);

        checkOutput("final_expq", expQ.size(), 0);
        checkOutput("final_slvq", slvQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
